// File: rtl/bcd_serial_adder_ctrl.sv
// Purpose: digit-serial packed-BCD adder, one digit per clock through a single
//          BCD slice, LSD first, with start/busy/done handshake and accumulate.
// Latency: start sampled at edge E0, done high for the cycle after edge E(DIGITS).
// Backpressure: none; start is sampled only in IDLE and is never queued.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        request a new addition (IDLE only)
//   acc          with start: 1 = operand A is the current sum register
//   a, b         packed BCD operands, digit k at [4k+3:4k]
//   cin          carry into digit 0, sampled with start
//   busy         high while digits are being processed
//   done         one-cycle pulse, sum/cout/err final
//   sum          packed BCD result register (feeds the display decoders)
//   cout         decimal carry out of the most-significant digit
//   err          an operand digit was >9 during the last operation

module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  acc,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx;

  // Single-digit BCD slice operating on digit idx of the captured operands.
  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic [4:0] dig_t;
  logic [4:0] dig_adj;
  logic [3:0] dig_sum;
  logic       carry_nxt;
  logic       dig_bad;

  // Operand digit mux written as a compare loop so the select stays a plain
  // equality on idx regardless of how DIGITS maps onto index widths.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDXW'(k)) begin
        dig_a = a_q[4*k +: 4];
        dig_b = b_q[4*k +: 4];
      end
    end
  end

  always_comb begin
    dig_t     = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_q};
    dig_adj   = dig_t + 5'd6;
    dig_sum   = dig_t[3:0];
    carry_nxt = 1'b0;
    // Decimal correction: anything above 9 wraps by +6 and carries. The same
    // rule is applied to non-BCD digits; the result is then defined but not BCD.
    if (dig_t > 5'd9) begin
      dig_sum   = dig_adj[3:0];
      carry_nxt = 1'b1;
    end
    dig_bad = (dig_a > 4'd9) || (dig_b > 4'd9);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // In accumulate mode the old sum is copied into the A register
            // before the sum register is cleared for the new result.
            a_q     <= acc ? sum : a;
            b_q     <= b;
            carry_q <= cin;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_ADD;
          end
        end

        S_ADD: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDXW'(k)) begin
              sum[4*k +: 4] <= dig_sum;
            end
          end
          carry_q <= carry_nxt;
          if (dig_bad) begin
            err <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            cout  <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Purpose: self-checking bench for bcd_serial_adder_ctrl (DIGITS=4): directed
//          vector table, hand-written multi-cycle sequences, and random valid-BCD
//          operations checked against a decimal-arithmetic reference model.

module tb_bcd_serial_adder_ctrl;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10000;

  logic         clk;
  logic         reset;
  logic         start;
  logic         acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int errors = 0;
  int checks = 0;
  int ms     = 0;   // model's view of the sum register, as a decimal value

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .acc   (acc),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One complete operation: start pulse, latency/busy/done-pulse checks, result
  // checks. Inputs are scrambled right after the start edge to show that the
  // operation in flight depends only on the values captured with start.
  task automatic run_op(input string nm, input logic i_acc, input logic [W-1:0] i_a,
                        input logic [W-1:0] i_b, input logic i_cin,
                        input logic [W-1:0] e_sum, input logic e_cout, input logic e_err);
    int lat = 0;
    int bcnt = 0;
    bit got = 0;
    @(negedge clk);
    start = 1'b1; acc = i_acc; a = i_a; b = i_b; cin = i_cin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); acc = 1'($urandom);
    if (busy) bcnt++;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin got = 1; lat = k; end
    end
    check({nm, " latency"}, 64'(lat), 64'(D));
    check({nm, " busy_cycles"}, 64'(bcnt), 64'(D));
    check({nm, " sum"}, 64'(sum), 64'(e_sum));
    check({nm, " cout"}, 64'(cout), 64'(e_cout));
    check({nm, " err"}, 64'(err), 64'(e_err));
    @(negedge clk);
    check({nm, " done_drop"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    string        nm;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         er;
  } vec_t;

  vec_t vt[8];

  initial begin
    int dcount;
    int dpos[$];
    logic [W-1:0] ra, rb;
    logic         racc, rcin;
    int           ea, tot;

    vt[0] = '{"add_1234_5678", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vt[1] = '{"add_9999_0001", 1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{"add_cin_only",  1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[3] = '{"add_0500_0500", 1'b0, 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[4] = '{"acc_0999_cin",  1'b1, 16'h7777, 16'h0999, 1'b1, 16'h2000, 1'b0, 1'b0};
    vt[5] = '{"invalid_000A",  1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1};
    vt[6] = '{"err_clears",    1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[7] = '{"acc_wrap",      1'b1, 16'h1234, 16'h9998, 1'b0, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; acc = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, cout, err, sum}), 64'd0);
    reset = 1'b0;

    // Idle with start low: operand inputs wiggle, nothing may change.
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); acc = 1'($urandom);
      @(negedge clk);
      check("idle_hold", 64'({busy, done, cout, err, sum}), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].nm, vt[i].acc, vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].er);
      ms = bcd2int(vt[i].s);
    end

    // Second start while busy must be ignored: exactly one done, sum 0x2222.
    @(negedge clk);
    start = 1'b1; acc = 1'b0; a = 16'h1111; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h4444; b = 16'h4444;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignore_start done_count", 64'(dcount), 64'd1);
    check("ignore_start sum", 64'(sum), 64'h2222);
    ms = 2222;

    // Reset two ADD edges into an operation: immediate zero outputs, no done.
    @(negedge clk);
    start = 1'b1; acc = 1'b0; a = 16'h3456; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("abort_outputs", 64'({busy, done, cout, err, sum}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ms = 0;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    // First accumulate after reset uses A=0.
    run_op("acc_after_reset", 1'b1, 16'h5555, 16'h0123, 1'b0, 16'h0123, 1'b0, 1'b0);
    ms = 123;

    // start held high: operations back-to-back every D+2 cycles.
    @(negedge clk);
    start = 1'b1; acc = 1'b1; a = 16'h9999; b = 16'h0001; cin = 1'b0;
    for (int k = 1; k <= 3 * (D + 2) - 1; k++) begin
      @(negedge clk);
      if (done) dpos.push_back(k);
    end
    start = 1'b0;
    check("b2b done_count", 64'(dpos.size()), 64'd3);
    if (dpos.size() == 3) begin
      check("b2b interval1", 64'(dpos[1] - dpos[0]), 64'(D + 2));
      check("b2b interval2", 64'(dpos[2] - dpos[1]), 64'(D + 2));
    end
    ms = (ms + 3) % MOD;
    check("b2b sum", 64'(sum), 64'(int2bcd(ms)));
    repeat (4) @(negedge clk);

    // Random valid-BCD operations against the decimal model.
    for (int i = 0; i < 40; i++) begin
      ra   = rand_bcd();
      rb   = rand_bcd();
      racc = ($urandom_range(0, 3) == 0);
      rcin = 1'($urandom);
      ea   = racc ? ms : bcd2int(ra);
      tot  = ea + bcd2int(rb) + int'(rcin);
      run_op("random", racc, ra, rb, rcin, int2bcd(tot % MOD), (tot >= MOD), 1'b0);
      ms = tot % MOD;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
